// File: rtl/rv32i_types.sv
// Shared types for the result-broadcast path.
//   branch_tag_t : speculation tag carried by every in-flight result.
//   cdb_pkt_t    : packed view of one common-data-bus beat, sized for the
//                  widest configuration (ROB index up to 8 bits, up to 8 units).
//   NUM_FU_DEFAULT / ROB_WIDTH_DEFAULT : default arbiter geometry.
package rv32i_types;

    localparam int NUM_FU_DEFAULT    = 4;
    localparam int ROB_WIDTH_DEFAULT = 6;
    localparam int BR_TAG_WIDTH      = 3;
    localparam int ROB_WIDTH_MAX     = 8;
    localparam int FU_ID_WIDTH_MAX   = 3;

    typedef logic [BR_TAG_WIDTH-1:0] branch_tag_t;

    typedef struct packed {
        logic                       valid;
        logic [31:0]                data;
        logic [ROB_WIDTH_MAX-1:0]   rob;
        branch_tag_t                br_tag;
        logic [FU_ID_WIDTH_MAX-1:0] fu_id;
    } cdb_pkt_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin one-hot picker.
//   req       : request vector, one bit per requester.
//   ptr       : index where the search starts; wraps from N-1 to 0.
//   grant     : one-hot (or zero) of the first requester found from ptr.
//   grant_idx : binary index of that requester (0 when none).
//   any       : at least one request is present.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    // Walk offsets from farthest to nearest so the requester closest to
    // ptr (in wrap order) overwrites any earlier candidate.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any       = |req;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = $clog2(N)'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one completed functional-unit result per
// cycle and broadcasts it on a registered bus one cycle later.
//   clk, rst      : clock, asynchronous active-high reset.
//   fu_valid      : per-unit "result ready".
//   fu_data/rob/br_tag : per-unit result payload.
//   squash_valid/squash_tag : mispredict squash; matching results are drained.
//   fu_taken      : one-hot consume strobe back to the units (combinational).
//   cdb_valid/data/rob/br_tag/fu_id : registered broadcast.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU    = NUM_FU_DEFAULT,
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_FU-1:0]                  fu_valid,
    input  logic [NUM_FU-1:0][31:0]            fu_data,
    input  logic [NUM_FU-1:0][ROB_WIDTH-1:0]   fu_rob,
    input  branch_tag_t [NUM_FU-1:0]           fu_br_tag,
    input  logic                               squash_valid,
    input  branch_tag_t                        squash_tag,
    output logic [NUM_FU-1:0]                  fu_taken,
    output logic                               cdb_valid,
    output logic [31:0]                        cdb_data,
    output logic [ROB_WIDTH-1:0]               cdb_rob,
    output branch_tag_t                        cdb_br_tag,
    output logic [$clog2(NUM_FU)-1:0]          cdb_fu_id
);

    localparam int FW = $clog2(NUM_FU);

    logic [FW-1:0]     rr_ptr;
    logic [NUM_FU-1:0] squash_hit;
    logic [NUM_FU-1:0] squash_sel;
    logic              squash_any;
    logic [NUM_FU-1:0] pick_grant;
    logic [FW-1:0]     pick_idx;
    logic              pick_any;
    logic              grant_fire;

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_squash
            assign squash_hit[gi] = squash_valid && fu_valid[gi] &&
                                    (fu_br_tag[gi] == squash_tag);
        end
    endgenerate

    assign squash_any = |squash_hit;

    // Squashed results are drained lowest index first, independent of rr_ptr.
    always_comb begin
        squash_sel = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (squash_hit[i]) begin
                squash_sel    = '0;
                squash_sel[i] = 1'b1;
            end
        end
    end

    rr_picker #(.N(NUM_FU)) u_picker (
        .req       (fu_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // A drain cycle consumes a result without broadcasting it, so the normal
    // grant (and the pointer advance) only happens when nothing is squashed.
    assign grant_fire = !squash_any && pick_any;

    always_comb begin
        fu_taken = '0;
        if (!rst) begin
            fu_taken = squash_any ? squash_sel : pick_grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_data   <= '0;
            cdb_rob    <= '0;
            cdb_br_tag <= '0;
            cdb_fu_id  <= '0;
            rr_ptr     <= '0;
        end else begin
            cdb_valid <= grant_fire;
            if (grant_fire) begin
                cdb_data   <= fu_data[pick_idx];
                cdb_rob    <= fu_rob[pick_idx];
                cdb_br_tag <= fu_br_tag[pick_idx];
                cdb_fu_id  <= pick_idx;
                rr_ptr     <= (pick_idx == FW'(NUM_FU - 1)) ? '0 : pick_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters (2..8).
REQ-002 Parameter ROB_WIDTH, default 6, width of the ROB index carried on the CDB.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fu_valid  input  NUM_FU  requester i holds a completed result.
REQ-006 fu_data  input  NUM_FU x 32  result value per requester.
REQ-007 fu_rob  input  NUM_FU x ROB_WIDTH  destination ROB index per requester.
REQ-008 fu_br_tag  input  NUM_FU x branch_tag_t  speculation tag per requester.
REQ-009 squash_valid  input  1  branch mispredict squash this cycle.
REQ-010 squash_tag  input  branch_tag_t  tag being squashed.
REQ-011 fu_taken  output  NUM_FU  one-hot or zero; requester i's result is consumed this cycle (drives the unit's result_taken).
REQ-012 cdb_valid  output  1  registered broadcast valid.
REQ-013 cdb_data / cdb_rob / cdb_br_tag  output  32 / ROB_WIDTH / branch_tag_t  registered broadcast payload.
REQ-014 cdb_fu_id  output  $clog2(NUM_FU)  index of the requester that produced the broadcast.

Function
REQ-015 fu_taken SHALL be combinational from current-cycle inputs and state; at most one bit set per cycle.
REQ-016 Grant: round-robin search starting at rr_ptr, wrapping from NUM_FU-1 to 0; first i with fu_valid[i]=1 wins.
REQ-017 On a grant to i with no squash match: fu_taken[i]=1; next cycle cdb_valid=1, payload = fu_data[i], fu_rob[i], fu_br_tag[i], cdb_fu_id=i (latency exactly 1 cycle).
REQ-018 After a grant to i, rr_ptr SHALL become (i+1) mod NUM_FU; with no grant rr_ptr holds.
REQ-019 Fairness: a requester held valid SHALL be granted within NUM_FU cycles.
REQ-020 Squash drain: if squash_valid=1 and fu_br_tag[i]==squash_tag for a valid requester, that requester SHALL be given fu_taken[i]=1 in the same cycle (priority over normal grant, lowest index first), with no broadcast and rr_ptr unchanged.
REQ-021 If squash_valid=1 and registered cdb_br_tag==squash_tag while cdb_valid=1, the current broadcast stays visible this cycle; no further action (ROB discards it).
REQ-022 No valid requester and no squash: fu_taken=0, next cdb_valid=0, payload registers hold last values.
REQ-023 fu_taken SHALL never assert for a requester with fu_valid=0.
REQ-024 Requester-side contract: fu_valid and payload SHALL stay stable until fu_taken; arbiter need not buffer more than one in-flight broadcast.

Reset
REQ-025 While rst=1: cdb_valid=0, cdb_data=0, cdb_rob=0, cdb_br_tag=0, cdb_fu_id=0, rr_ptr=0.
REQ-026 fu_taken SHALL be 0 while rst=1 regardless of fu_valid.
REQ-027 Reset asserted mid-broadcast SHALL clear cdb_valid immediately (asynchronously); first grant after release starts at requester 0.

Structure
REQ-028 branch_tag_t and the cdb_pkt_t struct (valid, data, rob, br_tag, fu_id) SHALL live in rv32i_types; NUM_FU default as a package constant.
REQ-029 One sub-module, rr_picker (priority-rotate one-hot select from request vector and pointer), SHALL implement REQ-016; remaining logic stays in cdb_arbiter.

Verification
REQ-030 Single request: fu_valid=4'b0100, fu_data[2]=0x0000_00AB, fu_rob[2]=5 -> fu_taken=4'b0100 same cycle; next cycle cdb_valid=1, cdb_data=0xAB, cdb_rob=5, cdb_fu_id=2.
REQ-031 All four held valid from reset for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one broadcast per cycle.
REQ-032 Requester 1 held valid, others toggling valid every cycle -> requester 1 granted within 4 cycles; no fu_taken without fu_valid.
REQ-033 fu_valid=4'b0011, fu_br_tag[0]=squash_tag=3, squash_valid=1 -> fu_taken=4'b0001, next cdb_valid=0, rr_ptr unchanged; following cycle requester 1 broadcast.
REQ-034 rst pulsed while cdb_valid=1 and fu_valid=4'b1111 -> cdb_valid drops without a clock edge, fu_taken=0; after release first grant goes to requester 0.
REQ-035 Idle: fu_valid=0 for 3 cycles after a broadcast -> cdb_valid=0, payload unchanged, rr_ptr unchanged.
